// File: rtl/key_converter.sv
// Keyboard byte to game key code converter: synchronises the ASCII byte into clk,
// decodes WASD/JKL/space to codes 1..8 and registers the result as a level or one-shot pulse.
module key_converter #(
  parameter int SYNC_STAGES = 2,  // legal range 1..4
  parameter bit PULSE       = 1'b0
) (
  output logic [3:0] key,
  input  logic [7:0] keyboard,
  input  logic       clk,
  input  logic       rst_n
);

  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] sync_d [SYNC_STAGES];
  logic [3:0] dec;
  logic [3:0] prev_q, prev_d;
  logic [3:0] key_q, key_d;

  function automatic logic [3:0] decode(input logic [7:0] b);
    logic [3:0] code;
    code = 4'd0;
    case (b)
      8'h57, 8'h77: code = 4'd1;
      8'h41, 8'h61: code = 4'd2;
      8'h53, 8'h73: code = 4'd3;
      8'h44, 8'h64: code = 4'd4;
      8'h4A, 8'h6A: code = 4'd5;
      8'h4B, 8'h6B: code = 4'd6;
      8'h4C, 8'h6C: code = 4'd7;
      8'h20:        code = 4'd8;
      default:      code = 4'd0;
    endcase
    return code;
  endfunction

  always_comb begin
    sync_d[0] = keyboard;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign dec = decode(sync_q[SYNC_STAGES-1]);

  // prev tracks the decoded code, not the raw byte, so 'w' -> 'W' never re-triggers a pulse.
  always_comb begin
    prev_d = dec;
    key_d  = dec;
    if (PULSE) begin
      key_d = ((dec != 4'd0) && (dec != prev_q)) ? dec : 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 8'h00;
      end
      prev_q <= 4'd0;
      key_q  <= 4'd0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q <= prev_d;
      key_q  <= key_d;
    end
  end

  assign key = key_q;

endmodule

// File: tb/tb_key_converter.sv
// Directed bench for key_converter: level mode, pulse mode and single-stage synchroniser
// instances share one keyboard stimulus and are checked against hand-computed codes.
module tb_key_converter;

  logic       clk;
  logic       rst_n;
  logic [7:0] keyboard;
  logic [3:0] key_lvl, key_pls, key_s1;

  int tests_run;
  int tests_failed;

  key_converter u_lvl (
    .key(key_lvl), .keyboard(keyboard), .clk(clk), .rst_n(rst_n)
  );

  key_converter #(.PULSE(1'b1)) u_pls (
    .key(key_pls), .keyboard(keyboard), .clk(clk), .rst_n(rst_n)
  );

  key_converter #(.SYNC_STAGES(1)) u_s1 (
    .key(key_s1), .keyboard(keyboard), .clk(clk), .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle on the following falling edge.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [7:0] tbl_byte [20];
  logic [3:0] tbl_code [20];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    tbl_byte = '{8'h57, 8'h77, 8'h41, 8'h61, 8'h53, 8'h73, 8'h44, 8'h64,
                 8'h4A, 8'h6A, 8'h4B, 8'h6B, 8'h4C, 8'h6C, 8'h20,
                 8'h00, 8'h31, 8'h7A, 8'hFF, 8'h5B};
    tbl_code = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4,
                 4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd7, 4'd8,
                 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

    // Reset held with 'w' applied
    rst_n    = 1'b0;
    keyboard = 8'h77;
    #2;
    check("reset_lvl_immediate", key_lvl, 4'd0);
    check("reset_pls_immediate", key_pls, 4'd0);
    wait_edges(2);
    check("reset_lvl_held", key_lvl, 4'd0);
    check("reset_s1_held", key_s1, 4'd0);

    // Release and watch the first sample ripple through
    rst_n = 1'b1;
    wait_edges(2);
    check("release_lvl_edge2", key_lvl, 4'd0);
    check("release_s1_edge2", key_s1, 4'd1);
    wait_edges(1);
    check("release_lvl_edge3", key_lvl, 4'd1);
    check("release_pls_edge3", key_pls, 4'd1);
    wait_edges(1);
    check("release_pls_edge4", key_pls, 4'd0);
    check("release_lvl_edge4", key_lvl, 4'd1);

    // Full decode table in level mode
    for (int i = 0; i < 20; i++) begin
      keyboard = tbl_byte[i];
      wait_edges(5);
      check($sformatf("decode_lvl_%02h", tbl_byte[i]), key_lvl, tbl_code[i]);
      check($sformatf("decode_s1_%02h", tbl_byte[i]), key_s1, tbl_code[i]);
    end

    // Exact latency: 0x61 -> 0x64 -> 0x00 in 4-cycle windows
    keyboard = 8'h61;
    wait_edges(2);
    check("lat_a_edge2", key_lvl, 4'd0);
    wait_edges(1);
    check("lat_a_edge3", key_lvl, 4'd2);
    wait_edges(1);
    keyboard = 8'h64;
    wait_edges(2);
    check("lat_d_edge2", key_lvl, 4'd2);
    wait_edges(1);
    check("lat_d_edge3", key_lvl, 4'd4);
    wait_edges(1);
    keyboard = 8'h00;
    wait_edges(2);
    check("lat_0_edge2", key_lvl, 4'd4);
    wait_edges(1);
    check("lat_0_edge3", key_lvl, 4'd0);
    wait_edges(3);

    // Pulse mode: space held 10 cycles gives one pulse on edge 3
    keyboard = 8'h20;
    for (int i = 1; i <= 10; i++) begin
      wait_edges(1);
      check($sformatf("pls_space_c%0d", i), key_pls, (i == 3) ? 4'd8 : 4'd0);
    end
    keyboard = 8'h6B;
    for (int i = 1; i <= 6; i++) begin
      wait_edges(1);
      check($sformatf("pls_k_c%0d", i), key_pls, (i == 3) ? 4'd6 : 4'd0);
    end
    keyboard = 8'h4B;
    for (int i = 1; i <= 6; i++) begin
      wait_edges(1);
      check($sformatf("pls_K_c%0d", i), key_pls, 4'd0);
    end
    keyboard = 8'h00;
    wait_edges(5);
    check("pls_release", key_pls, 4'd0);
    keyboard = 8'h6B;
    for (int i = 1; i <= 6; i++) begin
      wait_edges(1);
      check($sformatf("pls_k_again_c%0d", i), key_pls, (i == 3) ? 4'd6 : 4'd0);
    end

    // Asynchronous reset mid-operation, pulsed between clock edges
    keyboard = 8'h73;
    wait_edges(1);
    wait_edges(1);
    check("mid_pls_pending_edge2", key_pls, 4'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_lvl_async_clear", key_lvl, 4'd0);
    check("mid_s1_async_clear", key_s1, 4'd0);
    #1;
    rst_n = 1'b1;
    wait_edges(1);
    check("mid_pls_aborted", key_pls, 4'd0);
    wait_edges(4);
    check("mid_lvl_settled", key_lvl, 4'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid2_lvl_async_clear", key_lvl, 4'd0);
    check("mid2_pls_async_clear", key_pls, 4'd0);
    #1;
    rst_n = 1'b1;
    wait_edges(2);
    check("mid2_lvl_edge2", key_lvl, 4'd0);
    check("mid2_s1_edge2", key_s1, 4'd3);
    wait_edges(1);
    check("mid2_lvl_edge3", key_lvl, 4'd3);
    check("mid2_pls_edge3", key_pls, 4'd3);
    wait_edges(1);
    check("mid2_pls_edge4", key_pls, 4'd0);

    // Single-stage synchroniser: 'd' shows after 2 edges
    keyboard = 8'h64;
    wait_edges(1);
    check("s1_d_edge1", key_s1, 4'd3);
    wait_edges(1);
    check("s1_d_edge2", key_s1, 4'd4);
    check("s1_lvl_still_old", key_lvl, 4'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
